// File: rtl/piano_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piano_pkg
//  Description : Shared constants and types for the piano key-scan front end.
//                NOTE_W           - width of the note code
//                NUM_KEYS_DEFAULT - default number of key inputs
//                key_state_t      - note FSM state encoding
//  Revision    : 1.0  initial release
// ============================================================================
package piano_pkg;

    localparam int NOTE_W           = 3;
    localparam int NUM_KEYS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        SUSTAIN = 2'd2
    } key_state_t;

endpackage
`default_nettype wire

// File: rtl/piano_key_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : piano_key_debounce
//  Description : One key's two-flop synchroniser followed by a debounce
//                counter. The stable level flips only after the synchronised
//                level has disagreed with it for DEBOUNCE_CYCLES consecutive
//                cycles; any agreeing cycle restarts the count.
//  Ports       : clk      - clock
//                rst_n    - asynchronous active-low reset
//                i_key    - raw asynchronous key level (1 = pressed)
//                o_stable - debounced key level
//  Revision    : 1.0  initial release
// ============================================================================
module piano_key_debounce
    import piano_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key,
    output logic o_stable
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_diff;

    assign w_diff   = r_sync2 ^ r_stable;
    assign o_stable = r_stable;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= ~r_stable;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/piano_key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : piano_key_scan
//  Description : Key input stage of the piano. Debounces NUM_KEYS raw keys,
//                picks the lowest-index pressed key and runs a monophonic
//                note FSM producing a registered note code, a valid level and
//                one-cycle note_on / note_off strobes.
//                Optional feature macro: PIANO_SUSTAIN_EN - adds a SUSTAIN
//                state that holds the note SUSTAIN_CYCLES after release.
//  Ports       : clk         - clock
//                rst_n       - asynchronous active-low reset
//                ena         - enable; low forces the FSM to IDLE
//                keys_in     - raw key levels (1 = pressed)
//                keys_stable - debounced key levels
//                note_code   - index of the sounding key
//                note_valid  - a note is sounding
//                note_on     - strobe on a new or changed note
//                note_off    - strobe when the note ends
//  Revision    : 1.0  initial release
// ============================================================================
module piano_key_scan
    import piano_pkg::*;
#(
    parameter int NUM_KEYS        = NUM_KEYS_DEFAULT,
    parameter int DEBOUNCE_CYCLES = 10000,
    parameter int SUSTAIN_CYCLES  = 2000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    input  logic [NUM_KEYS-1:0] keys_in,
    output logic [NUM_KEYS-1:0] keys_stable,
    output logic [NOTE_W-1:0]   note_code,
    output logic                note_valid,
    output logic                note_on,
    output logic                note_off
);

    logic [NUM_KEYS-1:0] w_stable;
    logic                w_any;
    logic [NOTE_W-1:0]   w_sel;

    key_state_t          r_state;
    key_state_t          w_state_nxt;
    logic [NOTE_W-1:0]   r_code;
    logic [NOTE_W-1:0]   w_code_nxt;
    logic                r_valid;
    logic                r_on;
    logic                r_off;
    logic                w_on_nxt;
    logic                w_off_nxt;

    // ------------------------------------------------------------------
    // Per-key synchroniser + debounce
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
        piano_key_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_key    (keys_in[gi]),
            .o_stable (w_stable[gi])
        );
    end

    assign keys_stable = w_stable;

    // Lowest index wins: scan from the top so lower indices overwrite.
    always_comb begin
        w_sel = '0;
        w_any = |w_stable;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (w_stable[i]) begin
                w_sel = NOTE_W'(i);
            end
        end
    end

`ifdef PIANO_SUSTAIN_EN
    localparam int SUS_W = $clog2(SUSTAIN_CYCLES);

    logic [SUS_W-1:0] r_sus_cnt;
    logic             w_sus_done;

    assign w_sus_done = (r_sus_cnt == SUS_W'(SUSTAIN_CYCLES - 1));

    // Runs only while the FSM stays in SUSTAIN, so every entry starts at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sus_cnt <= '0;
        end else if (r_state == SUSTAIN && w_state_nxt == SUSTAIN) begin
            r_sus_cnt <= r_sus_cnt + 1'b1;
        end else begin
            r_sus_cnt <= '0;
        end
    end
`else
    logic w_unused_sustain;
    assign w_unused_sustain = ^SUSTAIN_CYCLES;
`endif

    // ------------------------------------------------------------------
    // Note FSM: next state and next registered outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_on_nxt    = 1'b0;
        w_off_nxt   = 1'b0;
        if (!ena) begin
            w_state_nxt = IDLE;
            w_off_nxt   = r_valid;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        w_state_nxt = PLAYING;
                        w_code_nxt  = w_sel;
                        w_on_nxt    = 1'b1;
                    end
                end
                PLAYING: begin
                    if (!w_any) begin
`ifdef PIANO_SUSTAIN_EN
                        w_state_nxt = SUSTAIN;
`else
                        w_state_nxt = IDLE;
                        w_off_nxt   = 1'b1;
`endif
                    end else if (w_sel != r_code) begin
                        // Legato: change pitch without ending the note.
                        w_code_nxt = w_sel;
                        w_on_nxt   = 1'b1;
                    end
                end
`ifdef PIANO_SUSTAIN_EN
                SUSTAIN: begin
                    if (w_any) begin
                        w_state_nxt = PLAYING;
                        w_code_nxt  = w_sel;
                        w_on_nxt    = 1'b1;
                    end else if (w_sus_done) begin
                        w_state_nxt = IDLE;
                        w_off_nxt   = 1'b1;
                    end
                end
`endif
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_code  <= '0;
            r_valid <= 1'b0;
            r_on    <= 1'b0;
            r_off   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_valid <= (w_state_nxt != IDLE);
            r_on    <= w_on_nxt;
            r_off   <= w_off_nxt;
        end
    end

    assign note_code  = r_code;
    assign note_valid = r_valid;
    assign note_on    = r_on;
    assign note_off   = r_off;

endmodule
`default_nettype wire

// File: tb/tb_piano_key_scan.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piano_key_scan
//  Description : Self-checking bench for piano_key_scan. A reference model
//                predicts the outputs of every clock edge and queues them;
//                a monitor compares the DUT against the queue and checks
//                note strobes against a separate event queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_piano_key_scan;

    localparam int NK = 8;
    localparam int D  = 4;
    localparam int S  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic [NK-1:0] keys_in;
    logic [NK-1:0] keys_stable;
    logic [2:0]    note_code;
    logic          note_valid;
    logic          note_on;
    logic          note_off;

    always #5 clk = ~clk;

    piano_key_scan #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYCLES (D),
        .SUSTAIN_CYCLES  (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .keys_in     (keys_in),
        .keys_stable (keys_stable),
        .note_code   (note_code),
        .note_valid  (note_valid),
        .note_on     (note_on),
        .note_off    (note_off)
    );

    typedef struct {
        logic [NK-1:0] stable;
        logic          valid;
        logic [2:0]    code;
        logic          on;
        logic          off;
    } exp_t;

    typedef struct {
        logic       is_on;
        logic [2:0] code;
    } ev_t;

    exp_t exp_q[$];
    ev_t  ev_q[$];

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [NK-1:0] hist [0:D];   // hist[0] = raw keys sampled at the latest edge
    logic [NK-1:0] m_stable;
    logic          m_valid;
    logic          m_sus;
    int            m_scnt;
    logic [2:0]    m_code;
    logic          rst_lvl;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [NK-1:0] v);
        for (int i = 0; i < NK; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Predicts the outputs produced by the next rising edge.
    task automatic model_edge(input logic [NK-1:0] keys, input logic en);
        exp_t          e;
        ev_t           ev;
        int            sel;
        logic [NK-1:0] ns;
        logic          all_diff;
        e.on  = 1'b0;
        e.off = 1'b0;
        if (!rst_n) begin
            for (int j = 0; j <= D; j++) hist[j] = '0;
            m_stable = '0;
            m_valid  = 1'b0;
            m_sus    = 1'b0;
            m_scnt   = 0;
            m_code   = '0;
        end else begin
            sel = lowest(m_stable);
            if (!en) begin
                e.off   = m_valid;
                m_valid = 1'b0;
                m_sus   = 1'b0;
            end else if (!m_valid) begin
                if (sel >= 0) begin
                    m_valid = 1'b1;
                    m_code  = 3'(sel);
                    e.on    = 1'b1;
                end
            end else if (!m_sus) begin
                if (sel < 0) begin
`ifdef PIANO_SUSTAIN_EN
                    m_sus  = 1'b1;
                    m_scnt = 0;
`else
                    m_valid = 1'b0;
                    e.off   = 1'b1;
`endif
                end else if (3'(sel) != m_code) begin
                    m_code = 3'(sel);
                    e.on   = 1'b1;
                end
            end else begin
                if (sel >= 0) begin
                    m_sus  = 1'b0;
                    m_code = 3'(sel);
                    e.on   = 1'b1;
                end else if (m_scnt == S - 1) begin
                    m_sus   = 1'b0;
                    m_valid = 1'b0;
                    e.off   = 1'b1;
                end else begin
                    m_scnt++;
                end
            end
            // A key's level is accepted once the last D samples to have
            // cleared the synchroniser all disagree with the current level.
            ns = m_stable;
            for (int k = 0; k < NK; k++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= D; j++) begin
                    if (hist[j][k] == m_stable[k]) all_diff = 1'b0;
                end
                if (all_diff) ns[k] = ~m_stable[k];
            end
            m_stable = ns;
            for (int j = D; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = keys;
        end
        e.stable = m_stable;
        e.valid  = m_valid;
        e.code   = m_code;
        exp_q.push_back(e);
        if (e.on || e.off) begin
            ev.is_on = e.on;
            ev.code  = m_code;
            ev_q.push_back(ev);
        end
    endtask

    task automatic cyc(input logic [NK-1:0] keys, input logic en);
        @(negedge clk);
        rst_n   = rst_lvl;
        keys_in = keys;
        ena     = en;
        model_edge(keys, en);
    endtask

    task automatic seg(input logic [NK-1:0] keys, input logic en, input int n);
        for (int i = 0; i < n; i++) cyc(keys, en);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stable"}, int'(keys_stable), 0);
        check({tag, "_code"},   int'(note_code),   0);
        check({tag, "_valid"},  int'(note_valid),  0);
        check({tag, "_on"},     int'(note_on),     0);
        check({tag, "_off"},    int'(note_off),    0);
    endtask

    // Monitor: compares DUT outputs after every rising edge
    always @(posedge clk) begin
        exp_t e;
        ev_t  ev;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("keys_stable", int'(keys_stable), int'(e.stable));
            check("note_valid",  int'(note_valid),  int'(e.valid));
            check("note_code",   int'(note_code),   int'(e.code));
            check("note_on",     int'(note_on),     int'(e.on));
            check("note_off",    int'(note_off),    int'(e.off));
        end
        if (note_on && note_off) begin
            check("on_off_exclusive", 1, 0);
        end
        if (note_on || note_off) begin
            if (ev_q.size() == 0) begin
                check("unexpected_strobe", int'(note_on), 0);
            end else begin
                ev = ev_q.pop_front();
                check("strobe_kind", int'(note_on), int'(ev.is_on));
                check("strobe_code", int'(note_code), int'(ev.code));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NK-1:0] k;
        logic          en;
        int            hold;
        rst_n   = 1'b1;
        rst_lvl = 1'b0;
        ena     = 1'b0;
        keys_in = '0;
        #1 rst_n = 1'b0;
        #1 check_all_zero("reset");
        seg('0, 1'b0, 2);
        rst_lvl = 1'b1;

        // Single press, hold, release
        seg(8'h08, 1'b1, 12);
        seg(8'h00, 1'b1, 20);
        // Glitch shorter than the debounce window
        seg(8'h20, 1'b1, 3);
        seg(8'h00, 1'b1, 10);
        // Legato up and back down
        seg(8'h08, 1'b1, 10);
        seg(8'h0A, 1'b1, 10);
        seg(8'h08, 1'b1, 10);
        seg(8'h00, 1'b1, 20);
        // Simultaneous release and press
        seg(8'h08, 1'b1, 10);
        seg(8'h40, 1'b1, 10);
        seg(8'h00, 1'b1, 20);
        // Enable dropped mid-note
        seg(8'h08, 1'b1, 10);
        seg(8'h08, 1'b0, 3);
        seg(8'h08, 1'b1, 5);
        seg(8'h00, 1'b1, 20);

        // Asynchronous reset while a note sounds
        seg(8'h10, 1'b1, 10);
        @(negedge clk);
        #2 rst_n = 1'b0;
        rst_lvl = 1'b0;
        #1 check_all_zero("reset_mid");
        model_edge(keys_in, ena);
        seg(8'h10, 1'b1, 2);
        rst_lvl = 1'b1;
        seg(8'h00, 1'b1, 12);

        // Randomised segments
        k = '0;
        for (int i = 0; i < 160; i++) begin
            case ($urandom_range(0, 3))
                0:       k = '0;
                1:       k = NK'(1) << $urandom_range(0, NK - 1);
                2:       k = NK'($urandom_range(0, 255));
                default: k = k ^ (NK'(1) << $urandom_range(0, NK - 1));
            endcase
            en   = ($urandom_range(0, 9) != 0);
            hold = $urandom_range(1, 14);
            seg(k, en, hold);
        end
        seg('0, 1'b1, 25);

        repeat (3) @(posedge clk);
        #2;
        check("exp_queue_drained", exp_q.size(), 0);
        check("event_queue_drained", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/piano_key_scan.md
# piano_key_scan

Front-end input stage of the simple piano. It synchronises and debounces the eight raw key inputs and resolves them to a single monophonic note. It then drives the tone generator directly downstream with a note code, a valid level and one-cycle note-on/note-off strobes.

## Interface
Parameters:
- `NUM_KEYS`, 8: number of key inputs; fixes the `keys_in` and `keys_stable` widths.
- `DEBOUNCE_CYCLES`, 10000: consecutive cycles a synchronised key must differ from its stable value before the stable value flips. Minimum 2.
- `SUSTAIN_CYCLES`, 2000000: release hold time in cycles. Used only when `PIANO_SUSTAIN_EN` is defined.

Ports:
- `clk` input 1: the single clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `ena` input 1: design enable; low forces the note FSM to IDLE.
- `keys_in` input NUM_KEYS: raw, asynchronous key levels; 1 = pressed.
- `keys_stable` output NUM_KEYS: debounced key levels.
- `note_code` output 3: index of the selected key.
- `note_valid` output 1: a note is sounding.
- `note_on` output 1: one-cycle strobe on a new or changed note.
- `note_off` output 1: one-cycle strobe when the note ends.

## Operation
Per key:
- Two-flop synchroniser, then a debounce counter of width $clog2(DEBOUNCE_CYCLES).
- Counter clears on every cycle where the synchronised value equals the stable value.
- Counter increments while the two differ.
- When the counter reaches DEBOUNCE_CYCLES-1 and the values still differ, the stable value flips and the counter clears.
- Glitches shorter than DEBOUNCE_CYCLES are discarded.

Selection:
- Lowest-index pressed stable key wins, so ties resolve to lowest index.
- Selection is combinational from `keys_stable`.

FSM states:
- IDLE: `note_valid`=0.
  - Any stable key pressed and `ena`=1 → PLAYING; latch `note_code`, pulse `note_on`.
- PLAYING: `note_valid`=1.
  - Selected index differs from `note_code` (legato) → update `note_code`, pulse `note_on`, no `note_off`.
  - No key pressed → IDLE, pulse `note_off`. With `PIANO_SUSTAIN_EN`, go to SUSTAIN instead.
- SUSTAIN (macro only): `note_valid`=1; the sustain counter runs.
  - Key pressed → PLAYING; latch the code, pulse `note_on`. A re-press of the same key also pulses.
  - Counter reaches SUSTAIN_CYCLES-1 → IDLE, pulse `note_off`.
- `ena`=0 in any state → IDLE next edge. Pulse `note_off` if `note_valid` was 1. No `note_on` while `ena`=0.

Boundary cases:
- Simultaneous release of the current key and press of another (same cycle) is treated as legato: `note_on` only.
- `note_on` and `note_off` are never high in the same cycle.
- Debounce logic runs regardless of `ena`.

## Timing
- Reset (asynchronous): all synchronisers, counters and `keys_stable` = 0; FSM = IDLE; `note_code`=0, `note_valid`=0, `note_on`=0, `note_off`=0.
- A clean key edge sampled at edge 1 gives:
  - `keys_stable` updated at edge DEBOUNCE_CYCLES+2.
  - `note_code`/`note_valid`/`note_on` registered at edge DEBOUNCE_CYCLES+3.
  - Total latency: DEBOUNCE_CYCLES+3 cycles.
- Release → `note_off`: same latency.
- All outputs are registered.
- A strobe lasts exactly one cycle.

## Configuration
- `PIANO_SUSTAIN_EN` defined:
  - SUSTAIN state and sustain counter are compiled in.
  - The counter width is $clog2(SUSTAIN_CYCLES).
- Undefined:
  - No SUSTAIN state; PLAYING→IDLE happens directly on release.
  - The `SUSTAIN_CYCLES` parameter is ignored.

## Structure
- `piano_pkg` holds:
  - `NOTE_W`=3.
  - FSM state enum `key_state_t`: IDLE, PLAYING, SUSTAIN.
  - Default `NUM_KEYS`.
- Sub-module `piano_key_debounce` contains one key's synchroniser and debounce counter. It is instantiated NUM_KEYS times via generate.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and SUSTAIN_CYCLES=8.
- Reset: assert `rst_n`=0 mid-note → all outputs 0 immediately, with no clock edge needed.
- Single press: set `keys_in`=0x08 and hold → `note_on` for one cycle at edge 7, `note_code`=3, `note_valid`=1. Release → `note_off` 7 cycles later, `note_valid`=0.
- Glitch: `keys_in`=0x20 for 3 cycles → `keys_stable` stays 0, no strobes.
- Legato: hold 0x08, add 0x02 → `note_on`, `note_code`=1. Drop 0x02 → `note_on`, `note_code`=3, no `note_off`.
- Simultaneous: `keys_in` switches 0x08→0x40 in one cycle while playing → `note_on` with `note_code`=6, no `note_off`.
- `ena` low while playing → `note_off` at the next edge, `note_valid`=0. With `PIANO_SUSTAIN_EN`: release → `note_valid` held 8 cycles, then `note_off`.
